// File: rtl/lsu_mem_master.sv
// Load/store initiator with one request in flight, a doubleword memory port and read-modify-write for narrow stores.
// Optional build macro MISALIGN_TRAP_EN: misaligned requests skip memory and respond with rsp_err=1.
module lsu_mem_master #(
  parameter int unsigned MEM_RD_LAT = 1,
  parameter int unsigned ADDR_W     = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [63:0]       req_wdata,
  input  logic [4:0]        req_rd,
  output logic              rsp_valid,
  output logic [63:0]       rsp_rdata,
  output logic [4:0]        rsp_rd,
  output logic              rsp_err,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [63:0]       mem_write_data,
  input  logic [63:0]       mem_read_data
);

  localparam int unsigned DATA_W = 64;
  localparam int unsigned CNT_W  = 3;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MEM_RD_LAT - 1);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [1:0] {S_IDLE, S_RD, S_WR, S_RESP} state_t;

  state_t             state, state_d;
  logic [CNT_W-1:0]   cnt, cnt_d;
  logic               accept;
  logic               rd_done;

  logic [1:0]         req_size;
  logic [2:0]         req_off;
  logic               req_trap;

  logic               op_store;
  logic               op_unsigned;
  logic [1:0]         op_size;
  logic [2:0]         op_off;
  logic [DATA_W-1:0]  op_wdata;
  logic [4:0]         op_rd;

  logic [DATA_W-1:0]  load_shift;
  logic [DATA_W-1:0]  load_val;
  logic [DATA_W-1:0]  lane_mask;
  logic [DATA_W-1:0]  merge_val;

  assign accept  = req_valid && req_ready;
  assign rd_done = (state == S_RD) && (cnt == LAST_CNT);

  // Access size and naturally aligned lane offset; store funct3 with bit 2 set falls back to SD.
  always_comb begin
    req_size = (req_is_store && req_funct3[2]) ? SZ_D : req_funct3[1:0];
    req_off  = 3'b000;
    case (req_size)
      SZ_B:    req_off = req_addr[2:0];
      SZ_H:    req_off = {req_addr[2:1], 1'b0};
      SZ_W:    req_off = {req_addr[2], 2'b00};
      default: req_off = 3'b000;
    endcase
`ifdef MISALIGN_TRAP_EN
    req_trap = (req_off != req_addr[2:0]);
`else
    req_trap = 1'b0;
`endif
  end

  // Next-state logic and read-latency counter
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (accept) begin
          if (req_trap)
            state_d = S_RESP;
          else if (req_is_store && (req_size == SZ_D))
            state_d = S_WR;
          else
            state_d = S_RD;
        end
      end
      S_RD: begin
        if (cnt == LAST_CNT)
          state_d = op_store ? S_WR : S_RESP;
        else
          cnt_d = cnt + CNT_W'(1);
      end
      S_WR:    state_d = S_RESP;
      default: state_d = S_IDLE;
    endcase
  end

  // Load lane extraction with sign or zero extension
  always_comb begin
    load_shift = mem_read_data >> {op_off, 3'b000};
    load_val   = load_shift;
    case (op_size)
      SZ_B: load_val = op_unsigned ? {{(DATA_W-8){1'b0}}, load_shift[7:0]}
                                   : {{(DATA_W-8){load_shift[7]}}, load_shift[7:0]};
      SZ_H: load_val = op_unsigned ? {{(DATA_W-16){1'b0}}, load_shift[15:0]}
                                   : {{(DATA_W-16){load_shift[15]}}, load_shift[15:0]};
      SZ_W: load_val = op_unsigned ? {{(DATA_W-32){1'b0}}, load_shift[31:0]}
                                   : {{(DATA_W-32){load_shift[31]}}, load_shift[31:0]};
      default: load_val = load_shift;
    endcase
  end

  // Store lane merge into the doubleword read back from memory
  always_comb begin
    case (op_size)
      SZ_B:    lane_mask = DATA_W'(64'h0000_0000_0000_00FF);
      SZ_H:    lane_mask = DATA_W'(64'h0000_0000_0000_FFFF);
      SZ_W:    lane_mask = DATA_W'(64'h0000_0000_FFFF_FFFF);
      default: lane_mask = {DATA_W{1'b1}};
    endcase
    lane_mask = lane_mask << {op_off, 3'b000};
    merge_val = (mem_read_data & ~lane_mask) | ((op_wdata << {op_off, 3'b000}) & lane_mask);
  end

  // State register and state-decoded strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      req_ready <= 1'b1;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      rsp_valid <= 1'b0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      req_ready <= (state_d == S_IDLE);
      mem_read  <= (state_d == S_RD);
      mem_write <= (state_d == S_WR);
      rsp_valid <= (state_d == S_RESP);
    end
  end

  // Request capture, write data and response payload
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_store       <= 1'b0;
      op_unsigned    <= 1'b0;
      op_size        <= SZ_B;
      op_off         <= 3'b000;
      op_wdata       <= '0;
      op_rd          <= '0;
      mem_address    <= '0;
      mem_write_data <= '0;
      rsp_rdata      <= '0;
      rsp_rd         <= '0;
      rsp_err        <= 1'b0;
    end else begin
      if (accept) begin
        op_store    <= req_is_store;
        op_unsigned <= req_funct3[2];
        op_size     <= req_size;
        op_off      <= req_off;
        op_wdata    <= req_wdata;
        op_rd       <= req_rd;
        mem_address <= {req_addr[ADDR_W-1:3], 3'b000};
        if (req_trap) begin
          rsp_rdata <= '0;
          rsp_rd    <= req_rd;
          rsp_err   <= 1'b1;
        end else if (req_is_store && (req_size == SZ_D)) begin
          mem_write_data <= req_wdata;
        end
      end
      if (rd_done) begin
        if (op_store) begin
          mem_write_data <= merge_val;
        end else begin
          rsp_rdata <= load_val;
          rsp_rd    <= op_rd;
          rsp_err   <= 1'b0;
        end
      end
      if (state == S_WR) begin
        rsp_rdata <= '0;
        rsp_rd    <= op_rd;
        rsp_err   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// Bench for lsu_mem_master: scoreboarded requests against a small doubleword memory, two read latencies.
module tb_lsu_mem_master;

  localparam int unsigned ADDR_W = 64;

  typedef struct {
    logic [63:0] rdata;
    logic [4:0]  rd;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  exp_t sb[$];

  // DUT with MEM_RD_LAT=1
  logic              req_valid, req_ready, req_is_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic [4:0]        req_rd;
  logic              rsp_valid, rsp_err;
  logic [63:0]       rsp_rdata;
  logic [4:0]        rsp_rd;
  logic              mem_read, mem_write;
  logic [ADDR_W-1:0] mem_address;
  logic [63:0]       mem_write_data, mem_read_data;

  // DUT with MEM_RD_LAT=3
  logic              l3_req_valid, l3_req_ready, l3_req_is_store;
  logic [2:0]        l3_req_funct3;
  logic [ADDR_W-1:0] l3_req_addr;
  logic [63:0]       l3_req_wdata;
  logic [4:0]        l3_req_rd;
  logic              l3_rsp_valid, l3_rsp_err;
  logic [63:0]       l3_rsp_rdata;
  logic [4:0]        l3_rsp_rd;
  logic              l3_mem_read, l3_mem_write;
  logic [ADDR_W-1:0] l3_mem_address;
  logic [63:0]       l3_mem_write_data, l3_mem_read_data;

  logic [63:0] mem1 [32];
  logic [63:0] mem3 [32];

  always @(posedge clk) if (mem_write) mem1[mem_address[7:3]] <= mem_write_data;
  always @(posedge clk) if (l3_mem_write) mem3[l3_mem_address[7:3]] <= l3_mem_write_data;
  assign mem_read_data    = mem1[mem_address[7:3]];
  assign l3_mem_read_data = mem3[l3_mem_address[7:3]];

  lsu_mem_master #(.MEM_RD_LAT(1), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
  );

  lsu_mem_master #(.MEM_RD_LAT(3), .ADDR_W(ADDR_W)) dut_l3 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(l3_req_valid), .req_ready(l3_req_ready), .req_is_store(l3_req_is_store),
    .req_funct3(l3_req_funct3), .req_addr(l3_req_addr), .req_wdata(l3_req_wdata), .req_rd(l3_req_rd),
    .rsp_valid(l3_rsp_valid), .rsp_rdata(l3_rsp_rdata), .rsp_rd(l3_rsp_rd), .rsp_err(l3_rsp_err),
    .mem_read(l3_mem_read), .mem_write(l3_mem_write), .mem_address(l3_mem_address),
    .mem_write_data(l3_mem_write_data), .mem_read_data(l3_mem_read_data)
  );

  // One request on the latency-1 DUT: push expectation, drive, then pop and check on the response.
  task automatic do_req(input string name, input logic st, input logic [2:0] f3,
                        input logic [63:0] addr, input logic [63:0] wd, input logic [4:0] rd,
                        input logic [63:0] exp_data, input logic exp_err, input int exp_lat,
                        input int exp_rds, input int exp_wrs, input logic [63:0] exp_wdata);
    exp_t e;
    int cyc, rds, wrs, both;
    logic got;
    logic [63:0] wdat;
    e.rdata = exp_data; e.rd = rd; e.err = exp_err;
    sb.push_back(e);
    @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL %s ready_before: got %b want 1", name, req_ready);
    end
    req_valid = 1'b1; req_is_store = st; req_funct3 = f3; req_addr = addr; req_wdata = wd; req_rd = rd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; rds = 0; wrs = 0; both = 0; got = 1'b0; wdat = '0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (mem_read) rds++;
      if (mem_read && mem_write) both++;
      if (mem_write) begin
        wrs++;
        wdat = mem_write_data;
        n_tests++;
        if (mem_address !== {addr[63:3], 3'b000}) begin
          n_fail++; $display("FAIL %s wr_addr: got %h want %h", name, mem_address, {addr[63:3], 3'b000});
        end
      end
      if (rsp_valid) got = 1'b1;
    end
    n_tests++;
    if (!got) begin
      n_fail++; $display("FAIL %s timeout: no rsp_valid within %0d cycles", name, cyc);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      n_tests++;
      if (cyc != exp_lat) begin
        n_fail++; $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
      end
      n_tests++;
      if (rsp_rdata !== e.rdata) begin
        n_fail++; $display("FAIL %s rdata: got %h want %h", name, rsp_rdata, e.rdata);
      end
      n_tests++;
      if (rsp_rd !== e.rd || rsp_err !== e.err) begin
        n_fail++; $display("FAIL %s rd/err: got %0d/%b want %0d/%b", name, rsp_rd, rsp_err, e.rd, e.err);
      end
      n_tests++;
      if (rds != exp_rds || wrs != exp_wrs || both != 0) begin
        n_fail++; $display("FAIL %s strobes: got rd=%0d wr=%0d both=%0d want rd=%0d wr=%0d both=0",
                           name, rds, wrs, both, exp_rds, exp_wrs);
      end
      if (exp_wrs != 0) begin
        n_tests++;
        if (wdat !== exp_wdata) begin
          n_fail++; $display("FAIL %s wdata: got %h want %h", name, wdat, exp_wdata);
        end
      end
      @(negedge clk);
      n_tests++;
      if (rsp_valid !== 1'b0 || rsp_rdata !== e.rdata || rsp_err !== e.err) begin
        n_fail++; $display("FAIL %s hold: got valid=%b rdata=%h err=%b want 0/%h/%b",
                           name, rsp_valid, rsp_rdata, rsp_err, e.rdata, e.err);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = '0; req_addr = '0; req_wdata = '0; req_rd = '0;
    l3_req_valid = 1'b0; l3_req_is_store = 1'b0; l3_req_funct3 = '0; l3_req_addr = '0;
    l3_req_wdata = '0; l3_req_rd = '0;
    repeat (2) @(negedge clk);
    n_tests++;
    if (req_ready !== 1'b1 || l3_req_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_ready: got %b/%b want 1/1", req_ready, l3_req_ready);
    end
    n_tests++;
    if ({rsp_valid, mem_read, mem_write, rsp_err} !== 4'b0000 || rsp_rdata !== 64'd0 ||
        mem_address !== 64'd0 || mem_write_data !== 64'd0 || rsp_rd !== 5'd0) begin
      n_fail++; $display("FAIL reset_outputs: got v=%b r=%b w=%b e=%b rdata=%h addr=%h wdata=%h rd=%0d want all 0",
                         rsp_valid, mem_read, mem_write, rsp_err, rsp_rdata, mem_address, mem_write_data, rsp_rd);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_reset_abort();
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b011; req_addr = 64'h10; req_rd = 5'd3;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n_tests++;
    if (mem_read !== 1'b1) begin
      n_fail++; $display("FAIL abort_mid_rd: got mem_read=%b want 1", mem_read);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if (mem_read !== 1'b0 || mem_write !== 1'b0) begin
      n_fail++; $display("FAIL abort_async: got mem_read=%b mem_write=%b want 0/0", mem_read, mem_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL abort_ready: got %b want 1", req_ready);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid || mem_read || mem_write) seen = 1'b1;
    end
    n_tests++;
    if (seen !== 1'b0) begin
      n_fail++; $display("FAIL abort_quiet: got activity=%b want 0", seen);
    end
  endtask

  task automatic test_store_load();
    do_req("sd_0x10", 1'b1, 3'b011, 64'h10, 64'hDEADBEEFCAFEBABE, 5'd1, 64'd0, 1'b0, 2, 0, 1, 64'hDEADBEEFCAFEBABE);
    do_req("ld_0x10", 1'b0, 3'b011, 64'h10, 64'd0, 5'd2, 64'hDEADBEEFCAFEBABE, 1'b0, 2, 1, 0, 64'd0);
    do_req("sd_0x20", 1'b1, 3'b011, 64'h20, 64'h123456789ABCDEF0, 5'd3, 64'd0, 1'b0, 2, 0, 1, 64'h123456789ABCDEF0);
  endtask

  task automatic test_load_ext();
    do_req("lb_0x20",  1'b0, 3'b000, 64'h20, 64'd0, 5'd4,  64'hFFFFFFFFFFFFFFF0, 1'b0, 2, 1, 0, 64'd0);
    do_req("lbu_0x20", 1'b0, 3'b100, 64'h20, 64'd0, 5'd5,  64'h00000000000000F0, 1'b0, 2, 1, 0, 64'd0);
    do_req("lw_0x24",  1'b0, 3'b010, 64'h24, 64'd0, 5'd6,  64'h0000000012345678, 1'b0, 2, 1, 0, 64'd0);
    do_req("lh_0x22",  1'b0, 3'b001, 64'h22, 64'd0, 5'd7,  64'hFFFFFFFFFFFF9ABC, 1'b0, 2, 1, 0, 64'd0);
    do_req("lhu_0x26", 1'b0, 3'b101, 64'h26, 64'd0, 5'd8,  64'h0000000000001234, 1'b0, 2, 1, 0, 64'd0);
    do_req("lwu_0x20", 1'b0, 3'b110, 64'h20, 64'd0, 5'd9,  64'h000000009ABCDEF0, 1'b0, 2, 1, 0, 64'd0);
    do_req("l111_0x20", 1'b0, 3'b111, 64'h20, 64'd0, 5'd10, 64'h123456789ABCDEF0, 1'b0, 2, 1, 0, 64'd0);
  endtask

  task automatic test_misalign();
`ifdef MISALIGN_TRAP_EN
    do_req("lw_0x22_trap", 1'b0, 3'b010, 64'h22, 64'd0, 5'd11, 64'd0, 1'b1, 1, 0, 0, 64'd0);
`else
    do_req("lw_0x22_mask", 1'b0, 3'b010, 64'h22, 64'd0, 5'd11, 64'hFFFFFFFF9ABCDEF0, 1'b0, 2, 1, 0, 64'd0);
`endif
  endtask

  task automatic test_sub_store();
    do_req("sb_0x21", 1'b1, 3'b000, 64'h21, 64'h00000000000000AA, 5'd12, 64'd0, 1'b0, 3, 1, 1, 64'h123456789ABCAAF0);
    do_req("sw_0x14", 1'b1, 3'b010, 64'h14, 64'hFFFFFFFF11223344, 5'd13, 64'd0, 1'b0, 3, 1, 1, 64'h11223344CAFEBABE);
    do_req("sh_0x16", 1'b1, 3'b001, 64'h16, 64'h0000000000005566, 5'd14, 64'd0, 1'b0, 3, 1, 1, 64'h55663344CAFEBABE);
    do_req("ld_0x10_after", 1'b0, 3'b011, 64'h10, 64'd0, 5'd15, 64'h55663344CAFEBABE, 1'b0, 2, 1, 0, 64'd0);
    do_req("ld_0x20_after", 1'b0, 3'b011, 64'h20, 64'd0, 5'd16, 64'h123456789ABCAAF0, 1'b0, 2, 1, 0, 64'd0);
  endtask

  // Latency-3 DUT: stretched read phase and a held second request accepted only after RESP.
  task automatic test_rd_latency();
    exp_t e1, e2, e;
    logic got;
    int cyc, nrsp, run, max_run, rds, ready_bad, first_cyc, second_cyc, accept2_cyc;
    @(negedge clk);
    l3_req_valid = 1'b1; l3_req_is_store = 1'b1; l3_req_funct3 = 3'b011; l3_req_addr = 64'h20;
    l3_req_wdata = 64'h123456789ABCDEF0; l3_req_rd = 5'd0;
    @(posedge clk);
    #1 l3_req_valid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (l3_rsp_valid) got = 1'b1;
    end
    n_tests++;
    if (got !== 1'b1) begin
      n_fail++; $display("FAIL l3_preload: got rsp=%b want 1", got);
    end
    @(negedge clk);
    e1.rdata = 64'h123456789ABCDEF0; e1.rd = 5'd20; e1.err = 1'b0; sb.push_back(e1);
    e2.rdata = 64'h000000000000009A; e2.rd = 5'd21; e2.err = 1'b0; sb.push_back(e2);
    l3_req_valid = 1'b1; l3_req_is_store = 1'b0; l3_req_funct3 = 3'b011; l3_req_addr = 64'h20; l3_req_rd = 5'd20;
    @(posedge clk);
    #1 l3_req_funct3 = 3'b100; l3_req_addr = 64'h23; l3_req_rd = 5'd21;
    cyc = 0; nrsp = 0; run = 0; max_run = 0; rds = 0; ready_bad = 0;
    first_cyc = 0; second_cyc = 0; accept2_cyc = 0;
    while (nrsp < 2 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      if (l3_mem_read) begin
        rds++; run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
      if (nrsp == 0 && l3_req_ready) ready_bad++;
      if (l3_req_valid && l3_req_ready) accept2_cyc = cyc;
      else if (accept2_cyc != 0 && l3_req_valid) l3_req_valid = 1'b0;
      if (l3_rsp_valid) begin
        nrsp++;
        if (nrsp == 1) first_cyc = cyc; else second_cyc = cyc;
        e = sb.pop_front();
        n_tests++;
        if (l3_rsp_rdata !== e.rdata || l3_rsp_rd !== e.rd || l3_rsp_err !== e.err) begin
          n_fail++; $display("FAIL l3_rsp%0d: got %h/%0d/%b want %h/%0d/%b", nrsp,
                             l3_rsp_rdata, l3_rsp_rd, l3_rsp_err, e.rdata, e.rd, e.err);
        end
      end
    end
    l3_req_valid = 1'b0;
    sb.delete();
    n_tests++;
    if (nrsp != 2) begin
      n_fail++; $display("FAIL l3_timeout: got %0d responses want 2", nrsp);
    end
    n_tests++;
    if (first_cyc != 4 || accept2_cyc != 5 || second_cyc != 9) begin
      n_fail++; $display("FAIL l3_timing: got rsp1=%0d acc2=%0d rsp2=%0d want 4/5/9",
                         first_cyc, accept2_cyc, second_cyc);
    end
    n_tests++;
    if (rds != 6 || max_run != 3) begin
      n_fail++; $display("FAIL l3_read_cycles: got total=%0d run=%0d want 6/3", rds, max_run);
    end
    n_tests++;
    if (ready_bad != 0) begin
      n_fail++; $display("FAIL l3_ready_busy: got %0d ready cycles want 0", ready_bad);
    end
  endtask

  initial begin
    test_reset();
    test_reset_abort();
    test_store_load();
    test_load_ext();
    test_misalign();
    test_sub_store();
    test_rd_latency();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
